ps2_key_receiver: RTL and testbench
===================================

Name: ps2_key_receiver

Overview:
- Receive side of the PS/2 keyboard link. Deserialises device-to-host frames from the keyboard pins and decodes the make (E0-extended), break (F0) and typematic-repeat sequences.
- Presents the currently held key as last_key_received, which the game-state FSM and the game-logic block consume (for example 8'h29 = SPACE).
- Sits between the board PS2_CLK/PS2_DAT pins and the top-level game FSM.

Parameters:
- TIMEOUT_CYCLES, default 5000: number of idle clocks, counted from the last PS/2 falling edge, before a partial frame is discarded (100 us at 50 MHz).
- RELEASE_CLEARS, default 1: when 1, a break code matching the held key clears last_key_received to 8'h00.

Ports:
- clock  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- PS2_CLK  in  1  raw keyboard clock pin, asynchronous
- PS2_DAT  in  1  raw keyboard data pin, asynchronous
- last_key_received  out  8  code of the key currently held; 8'h00 when none
- key_code  out  8  code of the most recent completed key event
- key_valid  out  1  one-cycle pulse: key_code, key_released and key_extended are updated this cycle
- key_released  out  1  the event was a break
- key_extended  out  1  the event had an E0 prefix
- frame_error  out  1  one-cycle pulse on a bad start, parity or stop bit, or on timeout

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: every output is 0, the FSM goes to IDLE, the prefix flags are cleared, the bit counter and timeout counter are 0. Reset mid-frame abandons the frame with no pulse. Reset has priority over every other event.
- Input conditioning:
  - Each pin passes through a 2-FF synchronizer.
  - A falling edge is detected as sync_clk_q=1 and sync_clk=0. It is registered 3 clocks after the pin edge.
  - Data is sampled from sync_dat in the cycle the falling edge is detected.
- Frame format: 11 bits. Start bit 0, then 8 data bits LSB first, then odd parity, then stop bit 1.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on an edge with data=0, go to DATA and set bitcnt=0. An edge with data=1 is ignored, with no error.
  - DATA: on each edge, shift the bit into shreg[bitcnt] and increment bitcnt. After bit 7, go to PARITY.
  - PARITY: on the edge, store the bit and go to STOP.
  - STOP: on the edge, go to IDLE. The byte is accepted only if the stop bit is 1 and the XOR of the 8 data bits with the parity bit equals 1. Otherwise pulse frame_error for 1 cycle and clear the E0/F0 flags.
- Timeout:
  - The counter is cleared on every falling edge and while in IDLE.
  - In any non-IDLE state, when it reaches TIMEOUT_CYCLES-1 the FSM goes to IDLE, frame_error pulses, and the prefix flags clear.
  - An edge arriving in the same cycle as the timeout is treated as the timeout; that edge is dropped.
- Byte decode (in the cycle after the STOP edge is accepted):
  - 8'hE0: set ext_flag; no event.
  - 8'hF0: set brk_flag; no event.
  - Any other byte:
    - key_code <= byte, key_extended <= ext_flag, key_released <= brk_flag, key_valid pulses, then both flags clear.
    - If it is a make: last_key_received <= byte.
    - If it is a break and byte == last_key_received and RELEASE_CLEARS: last_key_received <= 8'h00. A break for any other key leaves last_key_received unchanged.
    - A typematic repeat (make equal to the held key) still pulses key_valid; last_key_received is unchanged.
- Latency: key_valid rises exactly 1 clock after the stop-bit edge is detected, i.e. 4 clocks after the PS2_CLK pin edge.
- Held outputs: key_code, key_released and key_extended hold their values until the next event. key_valid and frame_error are never high in the same cycle.
- No host-to-device transmission. The pins are inputs only.

Decomposition:
- Package ps2_pkg:
  - Constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, KEY_NONE=8'h00.
  - FSM state encoding (2-bit).
  - Frame length constant 11.
- One sub-module, ps2_sync_edge: 2-FF synchronizers for both pins plus a falling-edge pulse output. It is reusable by a future ps2 transmitter.

Test Plan:
- SPACE make: frame start 0, data 1,0,0,1,0,1,0,0, parity 0, stop 1 (0x29). Response: key_valid for 1 clock, key_code=0x29, key_released=0, last_key_received=0x29.
- SPACE break: F0 (parity 1) then 29. Response: no event after F0; after 29, key_valid with key_released=1 and key_code=0x29; last_key_received=0x00.
- Up-arrow: E0 then 75 (parity 0). Response: key_extended=1, key_code=0x75, last_key_received=0x75. Then E0 F0 75 gives key_released=1, key_extended=1, last_key_received=0x00.
- Parity error: 0x29 sent with parity 1. Response: frame_error pulse, no key_valid, last_key_received unchanged. A following good 0x1C frame (parity 0) gives key_code=0x1C.
- Timeout and reset: start bit plus 4 data bits, then PS2_CLK held high for TIMEOUT_CYCLES. Response: frame_error pulse, FSM in IDLE, and the next full 0x29 frame decodes correctly. Asserting reset mid-frame clears all outputs with no pulses.
- Repeat: 0x29 make sent 3 times. Response: 3 key_valid pulses, last_key_received stays 0x29, no frame_error.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants, state encoding and payload types for the PS/2 keyboard link.
package ps2_pkg;

    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned DATA_BITS  = FRAME_BITS - 3;
    localparam int unsigned BITCNT_W   = 4;
    localparam int unsigned BITIDX_W   = $clog2(DATA_BITS);

    localparam logic [DATA_BITS-1:0] PS2_EXT  = 8'hE0;
    localparam logic [DATA_BITS-1:0] PS2_BRK  = 8'hF0;
    localparam logic [DATA_BITS-1:0] KEY_NONE = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    typedef struct packed {
        logic [DATA_BITS-1:0] code;
        logic                 released;
        logic                 extended;
    } key_event_t;

    // Odd parity over data+parity and a high stop bit make a good frame
    function automatic logic frame_ok(input logic [DATA_BITS-1:0] data,
                                      input logic                 par,
                                      input logic                 stop);
        return stop & (^{data, par});
    endfunction

endpackage

// File: rtl/ps2_key_receiver_if.sv
// Decoded key event bus from the PS/2 receiver to the game FSM / game logic.
interface ps2_key_receiver_if;
    import ps2_pkg::*;

    logic [DATA_BITS-1:0] last_key_received;
    logic [DATA_BITS-1:0] key_code;
    logic                 key_valid;
    logic                 key_released;
    logic                 key_extended;
    logic                 frame_error;

    modport master (
        output last_key_received, key_code, key_valid,
               key_released, key_extended, frame_error
    );

    modport slave (
        input  last_key_received, key_code, key_valid,
               key_released, key_extended, frame_error
    );

endinterface

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the raw PS/2 pins and a falling-edge strobe on the clock pin.
module ps2_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic sync_dat,
    output logic fall_c
);

    logic clk_meta;
    logic sync_clk;
    logic sync_clk_q;
    logic dat_meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            clk_meta   <= 1'b0;
            sync_clk   <= 1'b0;
            sync_clk_q <= 1'b0;
            dat_meta   <= 1'b0;
            sync_dat   <= 1'b0;
        end else begin
            clk_meta   <= ps2_clk;
            sync_clk   <= clk_meta;
            sync_clk_q <= sync_clk;
            dat_meta   <= ps2_dat;
            sync_dat   <= dat_meta;
        end
    end

    assign fall_c = sync_clk_q & ~sync_clk;

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 device-to-host frame receiver with E0/F0 prefix decoding and held-key tracking.
module ps2_key_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 5000,
    parameter bit          RELEASE_CLEARS = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               PS2_CLK,
    input  logic               PS2_DAT,
    ps2_key_receiver_if.master key_if
);

    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(DATA_BITS - 1);

    logic sync_dat;
    logic fall_c;

    ps2_sync_edge u_sync (
        .clock    (clock),
        .reset    (reset),
        .ps2_clk  (PS2_CLK),
        .ps2_dat  (PS2_DAT),
        .sync_dat (sync_dat),
        .fall_c   (fall_c)
    );

    ps2_state_e           state_q,   state_d;
    logic [BITCNT_W-1:0]  bitcnt_q,  bitcnt_d;
    logic [DATA_BITS-1:0] shreg_q,   shreg_d;
    logic                 par_q,     par_d;
    logic [TO_W-1:0]      to_cnt_q,  to_cnt_d;
    logic                 byte_rdy_q, byte_rdy_d;
    logic                 frame_err_q, frame_err_d;
    logic                 timeout_c;

    logic                 ext_q,     ext_d;
    logic                 brk_q,     brk_d;
    key_event_t           evt_q,     evt_d;
    logic [DATA_BITS-1:0] last_q,    last_d;
    logic                 valid_q,   valid_d;

    // Frame FSM and timeout counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            par_q       <= 1'b0;
            to_cnt_q    <= '0;
            byte_rdy_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            to_cnt_q    <= to_cnt_d;
            byte_rdy_q  <= byte_rdy_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        par_d       = par_q;
        to_cnt_d    = to_cnt_q + TO_W'(1);
        byte_rdy_d  = 1'b0;
        frame_err_d = 1'b0;
        timeout_c   = (state_q != ST_IDLE) && (to_cnt_q == TO_LAST);

        if ((state_q == ST_IDLE) || fall_c) begin
            to_cnt_d = '0;
        end

        // A clock edge coinciding with the timeout is swallowed by the timeout
        if (timeout_c) begin
            state_d     = ST_IDLE;
            to_cnt_d    = '0;
            frame_err_d = 1'b1;
        end else if (fall_c) begin
            case (state_q)
                ST_IDLE: begin
                    if (!sync_dat) begin
                        state_d  = ST_DATA;
                        bitcnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shreg_d[bitcnt_q[BITIDX_W-1:0]] = sync_dat;
                    bitcnt_d = bitcnt_q + BITCNT_W'(1);
                    if (bitcnt_q == LAST_BIT) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_d   = sync_dat;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (frame_ok(shreg_q, par_q, sync_dat)) begin
                        byte_rdy_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Byte decode: prefix flags, event registers and held key
    always_ff @(posedge clock) begin
        if (reset) begin
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            evt_q   <= '0;
            last_q  <= KEY_NONE;
            valid_q <= 1'b0;
        end else begin
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            evt_q   <= evt_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        ext_d   = ext_q;
        brk_d   = brk_q;
        evt_d   = evt_q;
        last_d  = last_q;
        valid_d = 1'b0;

        if (frame_err_d) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_rdy_q) begin
            if (shreg_q == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (shreg_q == PS2_BRK) begin
                brk_d = 1'b1;
            end else begin
                evt_d   = '{code: shreg_q, released: brk_q, extended: ext_q};
                valid_d = 1'b1;
                ext_d   = 1'b0;
                brk_d   = 1'b0;
                if (!brk_q) begin
                    last_d = shreg_q;
                end else if (RELEASE_CLEARS && (shreg_q == last_q)) begin
                    last_d = KEY_NONE;
                end
            end
        end
    end

    assign key_if.last_key_received = last_q;
    assign key_if.key_code          = evt_q.code;
    assign key_if.key_released      = evt_q.released;
    assign key_if.key_extended      = evt_q.extended;
    assign key_if.key_valid         = valid_q;
    assign key_if.frame_error       = frame_err_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed bench for ps2_key_receiver: a frame table plus latency, timeout and reset sequences.
module tb_ps2_key_receiver;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic PS2_CLK = 1'b1;
    logic PS2_DAT = 1'b1;

    ps2_key_receiver_if kif();

    ps2_key_receiver #(.TIMEOUT_CYCLES(5000), .RELEASE_CLEARS(1'b1)) dut (
        .clock   (clock),
        .reset   (reset),
        .PS2_CLK (PS2_CLK),
        .PS2_DAT (PS2_DAT),
        .key_if  (kif)
    );

    always #10 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int overlap_cnt = 0;

    // Pulse monitor, sampled away from the active edge
    always @(negedge clock) begin
        if (kif.key_valid)   valid_cnt++;
        if (kif.frame_error) err_cnt++;
        if (kif.key_valid && kif.frame_error) overlap_cnt++;
    end

    typedef struct {
        logic [7:0] data;
        bit         flip;
        bit         stop;
        int         dv;
        int         de;
        logic [7:0] code;
        bit         rel;
        bit         ext;
        logic [7:0] last;
    } vec_t;

    vec_t vt[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b);
        PS2_DAT = b;
        wait_clk(5);
        PS2_CLK = 1'b0;
        wait_clk(10);
        PS2_CLK = 1'b1;
        wait_clk(5);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit flip, input bit stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((~^d) ^ flip);
        send_bit(stop);
        PS2_DAT = 1'b1;
        wait_clk(10);
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] code, input bit rel,
                                 input bit ext, input logic [7:0] last);
        check({tag, " key_code"},     32'(kif.key_code),          32'(code));
        check({tag, " key_released"}, 32'(kif.key_released),      32'(rel));
        check({tag, " key_extended"}, 32'(kif.key_extended),      32'(ext));
        check({tag, " last_key"},     32'(kif.last_key_received), 32'(last));
    endtask

    initial begin
        int v0, e0, lat, highs;
        logic [7:0] lat_byte;

        vt[0]  = '{8'h29, 0, 1, 1, 0, 8'h29, 0, 0, 8'h29};
        vt[1]  = '{8'hF0, 0, 1, 0, 0, 8'h29, 0, 0, 8'h29};
        vt[2]  = '{8'h29, 0, 1, 1, 0, 8'h29, 1, 0, 8'h00};
        vt[3]  = '{8'hE0, 0, 1, 0, 0, 8'h29, 1, 0, 8'h00};
        vt[4]  = '{8'h75, 0, 1, 1, 0, 8'h75, 0, 1, 8'h75};
        vt[5]  = '{8'hE0, 0, 1, 0, 0, 8'h75, 0, 1, 8'h75};
        vt[6]  = '{8'hF0, 0, 1, 0, 0, 8'h75, 0, 1, 8'h75};
        vt[7]  = '{8'h75, 0, 1, 1, 0, 8'h75, 1, 1, 8'h00};
        vt[8]  = '{8'h29, 0, 1, 1, 0, 8'h29, 0, 0, 8'h29};
        vt[9]  = '{8'h29, 1, 1, 0, 1, 8'h29, 0, 0, 8'h29};
        vt[10] = '{8'h1C, 0, 1, 1, 0, 8'h1C, 0, 0, 8'h1C};
        vt[11] = '{8'h29, 0, 1, 1, 0, 8'h29, 0, 0, 8'h29};
        vt[12] = '{8'h29, 0, 1, 1, 0, 8'h29, 0, 0, 8'h29};
        vt[13] = '{8'h29, 0, 1, 1, 0, 8'h29, 0, 0, 8'h29};
        vt[14] = '{8'hF0, 0, 1, 0, 0, 8'h29, 0, 0, 8'h29};
        vt[15] = '{8'h1C, 0, 1, 1, 0, 8'h1C, 1, 0, 8'h29};
        vt[16] = '{8'hE0, 0, 1, 0, 0, 8'h1C, 1, 0, 8'h29};
        vt[17] = '{8'h29, 1, 1, 0, 1, 8'h1C, 1, 0, 8'h29};
        vt[18] = '{8'h29, 0, 1, 1, 0, 8'h29, 0, 0, 8'h29};
        vt[19] = '{8'hF0, 0, 0, 0, 1, 8'h29, 0, 0, 8'h29};
        vt[20] = '{8'h29, 0, 1, 1, 0, 8'h29, 0, 0, 8'h29};

        // Reset state
        wait_clk(5);
        reset = 1'b0;
        wait_clk(3);
        check_outputs("reset", 8'h00, 0, 0, 8'h00);
        check("reset key_valid",   32'(kif.key_valid),   32'd0);
        check("reset frame_error", 32'(kif.frame_error), 32'd0);

        // Frame table
        for (int i = 0; i < 21; i++) begin
            v0 = valid_cnt;
            e0 = err_cnt;
            send_frame(vt[i].data, vt[i].flip, vt[i].stop);
            check($sformatf("v%0d valid pulses", i), 32'(valid_cnt - v0), 32'(vt[i].dv));
            check($sformatf("v%0d error pulses", i), 32'(err_cnt - e0),   32'(vt[i].de));
            check_outputs($sformatf("v%0d", i), vt[i].code, vt[i].rel, vt[i].ext, vt[i].last);
        end

        // Latency: key_valid 4 clocks after the stop-bit pin edge, one cycle wide
        lat_byte = 8'h1C;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(lat_byte[i]);
        send_bit(~^lat_byte);
        PS2_DAT = 1'b1;
        wait_clk(5);
        PS2_CLK = 1'b0;
        lat = 0;
        highs = 0;
        for (int n = 1; n <= 10; n++) begin
            wait_clk(1);
            if (kif.key_valid) begin
                highs++;
                if (lat == 0) lat = n;
            end
        end
        PS2_CLK = 1'b1;
        wait_clk(10);
        check("latency clocks", 32'(lat), 32'd4);
        check("valid width", 32'(highs), 32'd1);
        check_outputs("latency", 8'h1C, 0, 0, 8'h1C);

        // Timeout on a partial frame; it also drops a pending E0
        send_frame(8'hE0, 0, 1);
        v0 = valid_cnt;
        e0 = err_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        PS2_DAT = 1'b1;
        wait_clk(4900);
        check("timeout early", 32'(err_cnt - e0), 32'd0);
        wait_clk(200);
        check("timeout error", 32'(err_cnt - e0), 32'd1);
        check("timeout valid", 32'(valid_cnt - v0), 32'd0);
        check("timeout last_key", 32'(kif.last_key_received), 32'h1C);
        send_frame(8'h29, 0, 1);
        check("after timeout valid", 32'(valid_cnt - v0), 32'd1);
        check_outputs("after timeout", 8'h29, 0, 0, 8'h29);

        // Reset mid-frame with an E0 pending
        send_frame(8'hE0, 0, 1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        v0 = valid_cnt;
        e0 = err_cnt;
        reset = 1'b1;
        wait_clk(2);
        check_outputs("mid reset", 8'h00, 0, 0, 8'h00);
        reset = 1'b0;
        PS2_DAT = 1'b1;
        wait_clk(6000);
        check("post reset valid", 32'(valid_cnt - v0), 32'd0);
        check("post reset error", 32'(err_cnt - e0),   32'd0);
        check_outputs("post reset", 8'h00, 0, 0, 8'h00);
        send_frame(8'h29, 0, 1);
        check("after reset valid", 32'(valid_cnt - v0), 32'd1);
        check_outputs("after reset", 8'h29, 0, 0, 8'h29);

        check("valid/error overlap", 32'(overlap_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
